// File: rtl/stack_seq.sv
// rtl/stack_seq.sv - PSH/PUL stack sequencer; optional PC load port under STACK_SEQ_NEWPC_EN
module stack_seq (
  input  logic        clk_in,
  input  logic        reset_n,
  input  logic        start,
  input  logic        pull,
  input  logic        use_s,
  input  logic [7:0]  postbyte,
  input  logic [15:0] reg_su,
  input  logic [15:0] path_left_data,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_ready,
  output logic [3:0]  path_left_addr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_o,
  output logic        dec_su,
  output logic        inc_su,
  output logic        write_reg,
  output logic [3:0]  write_reg_addr,
  output logic [15:0] data_w,
  output logic        busy,
`ifdef STACK_SEQ_NEWPC_EN
  output logic        done,
  output logic        write_pc,
  output logic [15:0] new_pc
`else
  output logic        done
`endif
);

  typedef enum logic [2:0] {IDLE, SEL, DEC, WR, RD, INC, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  mask_q;
  logic        pull_q;
  logic [2:0]  bit_q;
  logic        byte_q;
  logic [7:0]  hi_q;
  logic [7:0]  lo_q;

  logic        sel_found;
  logic [2:0]  sel_bit;
  logic [3:0]  cur_code;
  logic        is_wide;
  logic        last_byte;
  logic [15:0] pulled_val;
`ifdef STACK_SEQ_NEWPC_EN
  logic        is_pc;
`endif

  // Register code for a postbyte bit; the U/S slot names the other stack
  function automatic logic [3:0] reg_code(input logic [2:0] b, input logic s);
    case (b)
      3'd7:    reg_code = 4'd5;
      3'd6:    reg_code = s ? 4'd3 : 4'd4;
      3'd5:    reg_code = 4'd2;
      3'd4:    reg_code = 4'd1;
      3'd3:    reg_code = 4'd11;
      3'd2:    reg_code = 4'd9;
      3'd1:    reg_code = 4'd8;
      default: reg_code = 4'd10;
    endcase
  endfunction

  // Bits 7..4 are the 16-bit registers; the low byte goes out first on push,
  // the high byte comes in first on pull, so byte_q=1 always means "second byte"
  assign cur_code   = reg_code(bit_q, use_s);
  assign is_wide    = bit_q[2];
  assign last_byte  = !is_wide || byte_q;
  assign pulled_val = is_wide ? {hi_q, lo_q} : {8'h00, lo_q};
`ifdef STACK_SEQ_NEWPC_EN
  assign is_pc      = (bit_q == 3'd7);
`endif

  // Next register to serve: push walks PC..CC (high bit first), pull CC..PC
  always_comb begin
    sel_found = 1'b0;
    sel_bit   = 3'd0;
    if (pull_q) begin
      for (int i = 7; i >= 0; i--) begin
        if (mask_q[i]) begin
          sel_found = 1'b1;
          sel_bit   = 3'(i);
        end
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (mask_q[i]) begin
          sel_found = 1'b1;
          sel_bit   = 3'(i);
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latches: mask, direction, current register/byte and pulled bytes
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= 8'h00;
      pull_q <= 1'b0;
      bit_q  <= 3'd0;
      byte_q <= 1'b0;
      hi_q   <= 8'h00;
      lo_q   <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            mask_q <= postbyte;
            pull_q <= pull;
            byte_q <= 1'b0;
            hi_q   <= 8'h00;
            lo_q   <= 8'h00;
          end
        end
        SEL: begin
          if (sel_found) begin
            bit_q           <= sel_bit;
            mask_q[sel_bit] <= 1'b0;
            byte_q          <= 1'b0;
          end
        end
        WR: begin
          if (mem_ready && !last_byte) begin
            byte_q <= 1'b1;
          end
        end
        RD: begin
          if (mem_ready) begin
            if (is_wide && !byte_q) begin
              hi_q <= mem_data_i;
            end else begin
              lo_q <= mem_data_i;
            end
          end
        end
        INC: begin
          if (!last_byte) begin
            byte_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and outputs, all decoded from the current state and latches
  always_comb begin
    state_d        = state_q;
    path_left_addr = 4'h0;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr       = 16'h0000;
    mem_data_o     = 8'h00;
    dec_su         = 1'b0;
    inc_su         = 1'b0;
    write_reg      = 1'b0;
    write_reg_addr = 4'h0;
    data_w         = 16'h0000;
    busy           = 1'b0;
    done           = 1'b0;
`ifdef STACK_SEQ_NEWPC_EN
    write_pc       = 1'b0;
    new_pc         = 16'h0000;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEL;
        end
      end
      SEL: begin
        busy = 1'b1;
        if (!sel_found) begin
          state_d = DONE;
        end else if (pull_q) begin
          state_d = RD;
        end else begin
          state_d = DEC;
        end
      end
      DEC: begin
        busy    = 1'b1;
        dec_su  = 1'b1;
        state_d = WR;
      end
      WR: begin
        busy           = 1'b1;
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        mem_addr       = reg_su;
        path_left_addr = cur_code;
        mem_data_o     = (is_wide && byte_q) ? path_left_data[15:8] : path_left_data[7:0];
        if (mem_ready) begin
          state_d = last_byte ? SEL : DEC;
        end
      end
      RD: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = reg_su;
        if (mem_ready) begin
          state_d = INC;
        end
      end
      INC: begin
        busy   = 1'b1;
        inc_su = 1'b1;
        if (last_byte) begin
`ifdef STACK_SEQ_NEWPC_EN
          if (is_pc) begin
            write_pc = 1'b1;
            new_pc   = pulled_val;
          end else begin
            write_reg      = 1'b1;
            write_reg_addr = cur_code;
            data_w         = pulled_val;
          end
`else
          write_reg      = 1'b1;
          write_reg_addr = cur_code;
          data_w         = pulled_val;
`endif
          state_d = SEL;
        end else begin
          state_d = RD;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stack_seq.sv
// tb/tb_stack_seq.sv - self-checking bench for stack_seq against a transaction-level stack model
module tb_stack_seq;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } ev_t;

`ifdef STACK_SEQ_NEWPC_EN
  localparam bit NEWPC = 1'b1;
`else
  localparam bit NEWPC = 1'b0;
`endif

  logic        clk_in;
  logic        reset_n;
  logic        start;
  logic        pull;
  logic        use_s;
  logic [7:0]  postbyte;
  logic [15:0] reg_su;
  logic [15:0] path_left_data;
  logic [7:0]  mem_data_i;
  logic        mem_ready;
  logic [3:0]  path_left_addr;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_o;
  logic        dec_su;
  logic        inc_su;
  logic        write_reg;
  logic [3:0]  write_reg_addr;
  logic [15:0] data_w;
  logic        busy;
  logic        done;
`ifdef STACK_SEQ_NEWPC_EN
  logic        write_pc;
  logic [15:0] new_pc;
`endif

  stack_seq dut (
    .clk_in         (clk_in),
    .reset_n        (reset_n),
    .start          (start),
    .pull           (pull),
    .use_s          (use_s),
    .postbyte       (postbyte),
    .reg_su         (reg_su),
    .path_left_data (path_left_data),
    .mem_data_i     (mem_data_i),
    .mem_ready      (mem_ready),
    .path_left_addr (path_left_addr),
    .mem_req        (mem_req),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_data_o     (mem_data_o),
    .dec_su         (dec_su),
    .inc_su         (inc_su),
    .write_reg      (write_reg),
    .write_reg_addr (write_reg_addr),
    .data_w         (data_w),
    .busy           (busy),
`ifdef STACK_SEQ_NEWPC_EN
    .done           (done),
    .write_pc       (write_pc),
    .new_pc         (new_pc)
`else
    .done           (done)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int tests = 0;
  int errors = 0;

  // Register block and memory models
  logic [15:0] regval [16];
  logic [7:0]  mem [65536];
  logic        sp_load;
  logic [15:0] sp_init;
  assign path_left_data = regval[path_left_addr];
  assign mem_data_i     = mem[mem_addr];

  // Stack pointer follows the sequencer's strobes, as the register block would
  always @(posedge clk_in) begin
    if (sp_load) reg_su <= sp_init;
    else if (dec_su) reg_su <= reg_su - 16'd1;
    else if (inc_su) reg_su <= reg_su + 16'd1;
  end

  // Observation state
  ev_t obs_wr[$];
  ev_t obs_reg[$];
  ev_t obs_pc[$];
  int  n_dec, n_inc, n_done, n_viol, n_req, n_stall;
  int  ready_mode;
  int  stall_left;
  logic        prev_stall;
  logic [15:0] prev_addr;
  logic [7:0]  prev_dout;
  logic        prev_we;

  // Negedge monitor: drives mem_ready, records completed accesses and strobes
  always @(negedge clk_in) begin
    if (reset_n !== 1'b1) begin
      prev_stall = 1'b0;
    end else begin
      if (ready_mode == 0) mem_ready = 1'b1;
      else if (ready_mode == 1) mem_ready = 1'($urandom_range(0, 1));
      else if (mem_req && mem_we && stall_left > 0) begin
        mem_ready = 1'b0;
        stall_left--;
      end else mem_ready = 1'b1;
      if (prev_stall && (!mem_req || mem_addr !== prev_addr || mem_data_o !== prev_dout ||
                         mem_we !== prev_we || dec_su))
        n_viol++;
      if ((dec_su || inc_su || write_reg) && mem_req) n_viol++;
      if (dec_su) n_dec++;
      if (inc_su) n_inc++;
      if (done) n_done++;
      if (mem_req) n_req++;
      if (mem_req && !mem_ready) n_stall++;
      if (mem_req && mem_ready && mem_we) begin
        obs_wr.push_back({mem_addr, 8'h00, mem_data_o});
        mem[mem_addr] = mem_data_o;
      end
      if (write_reg) obs_reg.push_back({12'h000, write_reg_addr, data_w});
`ifdef STACK_SEQ_NEWPC_EN
      if (write_pc) obs_pc.push_back({16'h0005, new_pc});
`endif
      prev_stall = mem_req && !mem_ready;
      prev_addr  = mem_addr;
      prev_dout  = mem_data_o;
      prev_we    = mem_we;
    end
  end

  // Reference model: expected transactions from the register list and stack rules
  ev_t exp_wr[$];
  ev_t exp_reg[$];
  ev_t exp_pc[$];
  int  exp_dec, exp_inc;
  logic [15:0] exp_sp;

  function automatic logic [3:0] code_of(input int b, input logic us);
    case (b)
      7: return 4'd5;
      6: return us ? 4'd3 : 4'd4;
      5: return 4'd2;
      4: return 4'd1;
      3: return 4'd11;
      2: return 4'd9;
      1: return 4'd8;
      default: return 4'd10;
    endcase
  endfunction

  task automatic build_model(input logic [7:0] pb, input logic pl, input logic us, input logic [15:0] sp0);
    logic [15:0] sp;
    logic [3:0]  code;
    logic [7:0]  hi, lo;
    logic [15:0] val;
    sp = sp0;
    exp_wr.delete(); exp_reg.delete(); exp_pc.delete();
    exp_dec = 0; exp_inc = 0;
    for (int k = 0; k < 8; k++) begin
      int b;
      b = pl ? k : 7 - k;
      if (!pb[b]) continue;
      code = code_of(b, us);
      if (!pl) begin
        sp = sp - 16'd1; exp_dec++;
        exp_wr.push_back({sp, 8'h00, regval[code][7:0]});
        if (b >= 4) begin
          sp = sp - 16'd1; exp_dec++;
          exp_wr.push_back({sp, 8'h00, regval[code][15:8]});
        end
      end else begin
        if (b >= 4) begin
          hi = mem[sp]; sp = sp + 16'd1;
          lo = mem[sp]; sp = sp + 16'd1;
          exp_inc += 2;
          val = {hi, lo};
        end else begin
          lo = mem[sp]; sp = sp + 16'd1;
          exp_inc++;
          val = {8'h00, lo};
        end
        if (b == 7 && NEWPC) exp_pc.push_back({16'h0005, val});
        else exp_reg.push_back({12'h000, code, val});
      end
    end
    exp_sp = sp;
  endtask

  task automatic run_op(input logic [7:0] pb, input logic pl, input logic us, input logic [15:0] sp0,
                        input int mode, output int cyc, output bit tmo);
    @(posedge clk_in); #1;
    sp_init = sp0; sp_load = 1'b1;
    @(posedge clk_in); #1;
    sp_load = 1'b0;
    obs_wr.delete(); obs_reg.delete(); obs_pc.delete();
    n_dec = 0; n_inc = 0; n_done = 0; n_viol = 0; n_req = 0; n_stall = 0;
    ready_mode = mode; stall_left = 3;
    build_model(pb, pl, us, sp0);
    postbyte = pb; pull = pl; use_s = us; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 4000) begin
      @(posedge clk_in); #1;
      cyc++;
    end
    tmo = (done !== 1'b1);
    @(posedge clk_in); #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    tests++;
    if ({busy, done, mem_req, mem_we, dec_su, inc_su, write_reg} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000000", {busy, done, mem_req, mem_we, dec_su, inc_su, write_reg});
    end
    tests++;
    if ({mem_addr, data_w, mem_data_o, path_left_addr, write_reg_addr} !== 48'h0) begin
      errors++; $display("FAIL reset_buses: got %h expected 0", {mem_addr, data_w, mem_data_o, path_left_addr, write_reg_addr});
    end
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    n_req = 0;
    repeat (4) @(posedge clk_in);
    #1;
    tests++;
    if (n_req != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_idle: got req=%0d busy=%b expected req=0 busy=0", n_req, busy);
    end
  endtask

  task automatic test_push_full();
    int cyc; bit tmo;
    for (int i = 0; i < 16; i++) regval[i] = 16'($urandom);
    run_op(8'hFF, 1'b0, 1'b1, 16'h0F00, 0, cyc, tmo);
    tests++;
    if (tmo) begin errors++; $display("FAIL push_full timeout: got no done expected done"); end
    tests++;
    if (obs_wr.size() != 12) begin
      errors++; $display("FAIL push_full count: got %0d expected 12", obs_wr.size());
    end
    for (int i = 0; i < 12 && i < obs_wr.size(); i++) begin
      tests++;
      if (obs_wr[i] !== exp_wr[i] || obs_wr[i].a !== 16'h0EFF - 16'(i)) begin
        errors++; $display("FAIL push_full wr%0d: got %h expected %h", i, obs_wr[i], exp_wr[i]);
      end
    end
    tests++;
    if (n_dec != 12 || n_done != 1 || n_viol != 0 || reg_su !== 16'h0EF4) begin
      errors++; $display("FAIL push_full misc: got dec=%0d done=%0d viol=%0d sp=%h expected 12 1 0 0ef4", n_dec, n_done, n_viol, reg_su);
    end
  endtask

  task automatic test_pull_ab();
    int cyc; bit tmo;
    mem[16'h0E00] = 8'h12; mem[16'h0E01] = 8'h34;
    run_op(8'h06, 1'b1, 1'b1, 16'h0E00, 0, cyc, tmo);
    tests++;
    if (tmo || obs_reg.size() != 2) begin
      errors++; $display("FAIL pull_ab count: got %0d tmo=%0d expected 2 tmo=0", obs_reg.size(), tmo);
    end else begin
      tests++;
      if (obs_reg[0] !== {16'h0008, 16'h0012}) begin
        errors++; $display("FAIL pull_ab A: got %h expected 00080012", obs_reg[0]);
      end
      tests++;
      if (obs_reg[1] !== {16'h0009, 16'h0034}) begin
        errors++; $display("FAIL pull_ab B: got %h expected 00090034", obs_reg[1]);
      end
    end
    tests++;
    if (n_inc != 2 || n_dec != 0 || n_viol != 0) begin
      errors++; $display("FAIL pull_ab strobes: got inc=%0d dec=%0d viol=%0d expected 2 0 0", n_inc, n_dec, n_viol);
    end
  endtask

  task automatic test_empty();
    int cyc; bit tmo;
    run_op(8'h00, 1'b0, 1'b0, 16'h2000, 1, cyc, tmo);
    tests++;
    if (cyc != 2 || tmo) begin
      errors++; $display("FAIL empty latency: got %0d expected 2", cyc);
    end
    tests++;
    if (n_req != 0 || n_dec != 0 || n_inc != 0 || n_done != 1) begin
      errors++; $display("FAIL empty activity: got req=%0d dec=%0d inc=%0d done=%0d expected 0 0 0 1", n_req, n_dec, n_inc, n_done);
    end
  endtask

  task automatic test_stall();
    int cyc; bit tmo;
    run_op(8'h10, 1'b0, 1'b0, 16'h4000, 2, cyc, tmo);
    tests++;
    if (n_stall != 3 || n_viol != 0 || tmo) begin
      errors++; $display("FAIL stall hold: got stalls=%0d viol=%0d tmo=%0d expected 3 0 0", n_stall, n_viol, tmo);
    end
    tests++;
    if (obs_wr.size() != 2 || n_dec != 2) begin
      errors++; $display("FAIL stall count: got wr=%0d dec=%0d expected 2 2", obs_wr.size(), n_dec);
    end else begin
      tests++;
      if (obs_wr[0] !== {16'h3FFF, 8'h00, regval[1][7:0]} || obs_wr[1] !== {16'h3FFE, 8'h00, regval[1][15:8]}) begin
        errors++; $display("FAIL stall data: got %h %h expected %h %h", obs_wr[0], obs_wr[1], exp_wr[0], exp_wr[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc; bit tmo; int k;
    @(posedge clk_in); #1;
    sp_init = 16'h0F00; sp_load = 1'b1;
    @(posedge clk_in); #1;
    sp_load = 1'b0;
    obs_wr.delete(); ready_mode = 0;
    postbyte = 8'hFF; pull = 1'b0; use_s = 1'b1; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    k = 0;
    while (!(obs_wr.size() == 2 && mem_req === 1'b1) && k < 100) begin
      @(posedge clk_in); #1; k++;
    end
    tests++;
    if (k >= 100) begin errors++; $display("FAIL reset_mid reach: got no third write expected one"); end
    #2 reset_n = 1'b0;
    #1;
    tests++;
    if ({busy, mem_req, mem_we, dec_su, inc_su, write_reg, done} !== 7'b0 ||
        {mem_addr, mem_data_o, path_left_addr, data_w} !== 44'h0) begin
      errors++; $display("FAIL reset_mid async: got busy=%b req=%b addr=%h dout=%h expected all 0", busy, mem_req, mem_addr, mem_data_o);
    end
    @(posedge clk_in); #1;
    reset_n = 1'b1;
    n_req = 0;
    repeat (4) @(posedge clk_in);
    #1;
    tests++;
    if (n_req != 0) begin errors++; $display("FAIL reset_mid quiet: got req=%0d expected 0", n_req); end
    run_op(8'h01, 1'b0, 1'b1, 16'h0F00, 0, cyc, tmo);
    tests++;
    if (tmo || obs_wr.size() != 1) begin
      errors++; $display("FAIL reset_mid cc_count: got %0d expected 1", obs_wr.size());
    end else if (obs_wr[0] !== {16'h0EFF, 8'h00, regval[10][7:0]}) begin
      errors++; $display("FAIL reset_mid cc_data: got %h expected %h", obs_wr[0], {16'h0EFF, 8'h00, regval[10][7:0]});
    end
  endtask

  task automatic test_pull_pc();
    int cyc; bit tmo;
    ev_t got;
    mem[16'h1000] = 8'hAB; mem[16'h1001] = 8'hCD;
    run_op(8'h80, 1'b1, 1'b0, 16'h1000, 0, cyc, tmo);
    tests++;
    if (NEWPC) begin
      got = (obs_pc.size() == 1) ? obs_pc[0] : 32'hFFFFFFFF;
      if (tmo || got !== {16'h0005, 16'hABCD} || obs_reg.size() != 0) begin
        errors++; $display("FAIL pull_pc newpc: got %h regs=%0d expected 0005abcd regs=0", got, obs_reg.size());
      end
    end else begin
      got = (obs_reg.size() == 1) ? obs_reg[0] : 32'hFFFFFFFF;
      if (tmo || got !== {16'h0005, 16'hABCD}) begin
        errors++; $display("FAIL pull_pc reg: got %h expected 0005abcd", got);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc; bit tmo;
    logic [7:0] pb;
    ev_t all[$];
    pb = 8'($urandom) | 8'h81;
    run_op(pb, 1'b0, 1'b0, 16'h0004, 1, cyc, tmo);
    run_op(pb, 1'b1, 1'b0, 16'h0004 - 16'(exp_dec), 1, cyc, tmo);
    all = obs_reg;
    foreach (obs_pc[i]) all.push_back(obs_pc[i]);
    tests++;
    if (tmo || all.size() != $countones(pb) || reg_su !== 16'h0004) begin
      errors++; $display("FAIL b2b count: got %0d sp=%h expected %0d sp=0004", all.size(), reg_su, $countones(pb));
    end
    foreach (all[i]) begin
      logic [3:0] c;
      c = all[i].a[3:0];
      tests++;
      if (all[i].d !== ((c <= 4'd5) ? regval[c] : {8'h00, regval[c][7:0]})) begin
        errors++; $display("FAIL b2b reg%0d: got %h expected %h", c, all[i].d, regval[c]);
      end
    end
  endtask

  task automatic test_random();
    int cyc; bit tmo;
    logic [7:0] pb; logic pl; logic us; logic [15:0] sp0;
    for (int n = 0; n < 24; n++) begin
      pb  = 8'($urandom);
      pl  = 1'($urandom);
      us  = 1'($urandom);
      sp0 = (n % 6 == 0) ? 16'h0003 : (n % 6 == 1) ? 16'hFFFD : 16'($urandom);
      run_op(pb, pl, us, sp0, 1, cyc, tmo);
      tests++;
      if (tmo || n_viol != 0 || n_done != 1) begin
        errors++; $display("FAIL rand%0d proto: got tmo=%0d viol=%0d done=%0d expected 0 0 1", n, tmo, n_viol, n_done);
      end
      tests++;
      if (obs_wr != exp_wr) begin
        errors++; $display("FAIL rand%0d writes: got %0d entries expected %0d (pb=%h)", n, obs_wr.size(), exp_wr.size(), pb);
      end
      tests++;
      if (obs_reg != exp_reg || obs_pc != exp_pc) begin
        errors++; $display("FAIL rand%0d regwrites: got %0d/%0d expected %0d/%0d (pb=%h)", n, obs_reg.size(), obs_pc.size(), exp_reg.size(), exp_pc.size(), pb);
      end
      tests++;
      if (reg_su !== exp_sp || n_dec != exp_dec || n_inc != exp_inc) begin
        errors++; $display("FAIL rand%0d sp: got %h dec=%0d inc=%0d expected %h %0d %0d", n, reg_su, n_dec, n_inc, exp_sp, exp_dec, exp_inc);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pull = 1'b0; use_s = 1'b0; postbyte = 8'h00;
    mem_ready = 1'b1; ready_mode = 0; stall_left = 0; prev_stall = 1'b0;
    sp_load = 1'b1; sp_init = 16'h0000;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 16; i++) regval[i] = 16'($urandom);
    test_reset();
    test_push_full();
    test_pull_ab();
    test_empty();
    test_stall();
    test_reset_mid();
    test_pull_pc();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/stack_seq.md
STACK_SEQ -- requirements
Module: stack_seq

Interface
REQ-001 SHALL have port clk_in, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1: one-cycle request, sampled only in IDLE.
REQ-004 SHALL have port pull, input, 1: 0 = push (PSH), 1 = pull (PUL); latched at start.
REQ-005 SHALL have port use_s, input, 1: 1 = S stack, 0 = U stack; held stable by the sequencer's owner while busy.
REQ-006 SHALL have port postbyte, input, 8: register mask, latched at start. Bit order: b7 PC, b6 U/S, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC.
REQ-007 SHALL have port reg_su, input, 16: current stack pointer from the register block.
REQ-008 SHALL have port path_left_data, input, 16: register read data.
REQ-009 SHALL have port mem_data_i, input, 8: read data, valid with mem_ready.
REQ-010 SHALL have port mem_ready, input, 1: completes the current memory access.
REQ-011 SHALL have outputs path_left_addr (4), mem_req (1), mem_we (1), mem_addr (16), mem_data_o (8), dec_su (1), inc_su (1), write_reg (1), write_reg_addr (4), data_w (16), busy (1), done (1).

Function
REQ-012 Register codes SHALL be: X=1, Y=2, U=3, S=4, PC=5, A=8, B=9, CC=10, DP=11. The U/S bit SHALL select U (3) when use_s=1 and S (4) when use_s=0.
REQ-013 States SHALL be IDLE, SEL, DEC, WR, RD, INC, DONE.
REQ-014 IDLE with start=1 SHALL go to SEL. start seen outside IDLE SHALL be ignored.
REQ-015 SEL SHALL pick the next unserved mask bit and go to DEC (push) or RD (pull). If no bit remains, SEL SHALL go to DONE.
REQ-016 Push SHALL order registers PC, U/S, Y, X, DP, B, A, CC. Pull SHALL order them CC, A, B, DP, X, Y, U/S, PC.
REQ-017 Push order of bytes within a 16-bit register SHALL be low byte then high byte. Pull order SHALL be high byte then low byte. 8-bit registers SHALL use path_left_data[7:0].
REQ-018 DEC SHALL assert dec_su for exactly one cycle, then go to WR.
REQ-019 WR SHALL assert mem_req=1 and mem_we=1, with mem_addr=reg_su, path_left_addr set to the current register code, and mem_data_o set to the selected byte.
REQ-020 RD SHALL assert mem_req=1, mem_we=0 and mem_addr=reg_su.
REQ-021 In WR and RD, all outputs SHALL stay stable until mem_ready=1 is sampled. The state SHALL then advance on that edge: WR goes to DEC or SEL; RD latches mem_data_i and goes to INC.
REQ-022 INC SHALL assert inc_su for one cycle. On the INC of a register's final byte, it SHALL also assert write_reg=1, write_reg_addr set to the code, and data_w set to {hi,lo} for 16-bit registers or {8'h00,byte} for 8-bit registers. It SHALL then go to SEL or RD.
REQ-023 DONE SHALL assert done for one cycle, then go to IDLE.
REQ-024 busy SHALL be 1 in every state except IDLE and DONE.
REQ-025 dec_su, inc_su and write_reg SHALL never be asserted in the same cycle as mem_req.
REQ-026 mem_addr arithmetic SHALL wrap modulo 2^16 (the wrap itself is done by the register block).

Reset
REQ-027 On reset_n=0, the block SHALL enter IDLE immediately, including mid-operation. All strobes, mem_req, busy and done SHALL go to 0; the mask and byte latches SHALL clear; all data/address outputs SHALL be 16'h0000/8'h00/4'h0.
REQ-028 After reset release, no access SHALL be issued until a new start.

Configuration
REQ-029 With macro STACK_SEQ_NEWPC_EN defined, the block SHALL add outputs write_pc (1) and new_pc (16). A pulled PC SHALL be delivered as write_pc=1 with new_pc={hi,lo}, and write_reg SHALL stay 0 for that register.
REQ-030 Without STACK_SEQ_NEWPC_EN, write_pc and new_pc SHALL NOT exist, and PC SHALL be written through write_reg with code 5.

Verification
REQ-031 Push, postbyte=8'hFF, use_s=1, reg_su starting at 16'h0F00 and tracking dec_su, mem_ready tied 1 -> 12 writes at 0EFF down to 0EF4: PCL, PCH, UL, UH, YL, YH, XL, XH, DP, B, A, CC; then done for one cycle.
REQ-032 Pull, postbyte=8'h06, reg_su=16'h0E00, memory 0E00=8'h12, 0E01=8'h34 -> write_reg code 8 with data_w=16'h0012, then code 9 with data_w=16'h0034; inc_su pulsed twice.
REQ-033 postbyte=8'h00 -> done two clocks after start, with no mem_req, dec_su or inc_su.
REQ-034 mem_ready held low for 3 cycles during a WR -> mem_addr, mem_data_o and mem_we stay constant; no dec_su until the access completes.
REQ-035 reset_n pulsed low during the third byte of an 8'hFF push -> outputs go to 0 asynchronously; busy=0; a later start with postbyte=8'h01 pushes only CC.
REQ-036 Pull of PC (8'h80), memory 8'hAB, 8'hCD -> with STACK_SEQ_NEWPC_EN: write_pc=1, new_pc=16'hABCD; without it: write_reg=1, code 5, data_w=16'hABCD.
